// File: rtl/common.sv
// Shared definitions for the scalar core slice.
//
// Contents:
//   `DATA_WIDTH                 default data/address word width
//   `SCALAR_LSU_TIMEOUT_CYCLES  default handshake timeout limit for scalar_lsu
//   common_pkg                  data_t, warp_state_t, lsu_state_t
//
// The include guard lets this file be compiled on its own and also pulled in
// by the modules that need the defines, without redefinition.
`ifndef COMMON_SV
`define COMMON_SV

`define DATA_WIDTH 32
`define SCALAR_LSU_TIMEOUT_CYCLES 256

package common_pkg;

    typedef logic [`DATA_WIDTH-1:0] data_t;

    // Warp pipeline phases as seen by the execution units.
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

`endif

// File: rtl/scalar_lsu.sv
// Scalar load/store unit: issues one memory access per instruction using a
// valid/ready handshake and returns load data to the scalar register file.
//
// Build option: SCALAR_LSU_TIMEOUT_EN -- when defined, a request that sees no
// ready for TIMEOUT_CYCLES cycles is abandoned, lsu_error is raised and a load
// returns all ones. When undefined there is no counter and lsu_error is 0.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   enable, warp_state          warp enable and current warp phase
//   decoded_mem_read_enable     load instruction
//   decoded_mem_write_enable    store instruction (wins over load)
//   decoded_immediate, rs1      offset and base address
//   rs2                         store data
//   mem_read_*                  read request channel (valid/address out,
//                               ready/data in)
//   mem_write_*                 write request channel (valid/address/data out,
//                               ready in)
//   lsu_state                   FSM state
//   lsu_out                     last load result
//   lsu_error                   timeout flag for the last access
`include "common.sv"

module scalar_lsu
    import common_pkg::*;
#(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = `SCALAR_LSU_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  warp_state_t           warp_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] decoded_immediate,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  mem_read_valid,
    output logic [DATA_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [DATA_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
    output lsu_state_t            lsu_state,
    output logic [DATA_WIDTH-1:0] lsu_out,
    output logic                  lsu_error
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("scalar_lsu: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t            state_r;
    lsu_state_t            next_state_s;
    logic                  start_s;
    logic                  handshake_s;
    logic                  timeout_s;
    logic                  read_valid_r;
    logic                  write_valid_r;
    logic                  is_store_r;
    logic [DATA_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] lsu_out_r;

`ifdef SCALAR_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;
    logic             error_r;
`endif

    // Next-state decode and the one-cycle control strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        handshake_s  = 1'b0;
        timeout_s    = 1'b0;
        if (enable) begin
            case (state_r)
                LSU_IDLE: begin
                    if ((warp_state == WARP_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        next_state_s = LSU_REQUESTING;
                        start_s      = 1'b1;
                    end else begin
                        next_state_s = LSU_IDLE;
                    end
                end
                LSU_REQUESTING: begin
                    // A ready on the channel that is not being driven is ignored.
                    if ((read_valid_r && mem_read_ready) ||
                        (write_valid_r && mem_write_ready)) begin
                        next_state_s = LSU_WAITING;
                        handshake_s  = 1'b1;
`ifdef SCALAR_LSU_TIMEOUT_EN
                    end else if (count_r == CNT_LAST) begin
                        next_state_s = LSU_DONE;
                        timeout_s    = 1'b1;
`endif
                    end else begin
                        next_state_s = LSU_REQUESTING;
                    end
                end
                // Alignment slot so the register file sees lsu_out one cycle later.
                LSU_WAITING: begin
                    next_state_s = LSU_DONE;
                end
                LSU_DONE: begin
                    if (warp_state == WARP_UPDATE) begin
                        next_state_s = LSU_IDLE;
                    end else begin
                        next_state_s = LSU_DONE;
                    end
                end
                default: begin
                    next_state_s = LSU_IDLE;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // FSM state register; a disabled cycle holds the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LSU_IDLE;
        end else if (enable) begin
            state_r <= next_state_s;
        end
    end

    // Request channel and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_r  <= 1'b0;
            write_valid_r <= 1'b0;
            is_store_r    <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            lsu_out_r     <= '0;
        end else if (enable) begin
            if (start_s) begin
                // Store wins when both decoded enables are set.
                is_store_r    <= decoded_mem_write_enable;
                write_valid_r <= decoded_mem_write_enable;
                read_valid_r  <= ~decoded_mem_write_enable;
                addr_r        <= rs1 + decoded_immediate;
                if (decoded_mem_write_enable) begin
                    wdata_r <= rs2;
                end
            end else if (handshake_s) begin
                read_valid_r  <= 1'b0;
                write_valid_r <= 1'b0;
                if (!is_store_r) begin
                    lsu_out_r <= mem_read_data;
                end
            end else if (timeout_s) begin
                read_valid_r  <= 1'b0;
                write_valid_r <= 1'b0;
                if (!is_store_r) begin
                    lsu_out_r <= '1;
                end
            end
        end
    end

`ifdef SCALAR_LSU_TIMEOUT_EN
    // Requesting-cycle counter and sticky error flag for the current access.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            error_r <= 1'b0;
        end else if (enable) begin
            if (start_s) begin
                count_r <= '0;
                error_r <= 1'b0;
            end else if (timeout_s) begin
                count_r <= '0;
                error_r <= 1'b1;
            end else if (state_r == LSU_REQUESTING && !handshake_s) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign lsu_error = error_r;
`else
    assign lsu_error = 1'b0;
`endif

    assign lsu_state         = state_r;
    assign mem_read_valid    = read_valid_r;
    assign mem_read_address  = addr_r;
    assign mem_write_valid   = write_valid_r;
    assign mem_write_address = addr_r;
    assign mem_write_data    = wdata_r;
    assign lsu_out           = lsu_out_r;

endmodule

// File: tb/tb_scalar_lsu.sv
// Self-checking bench for scalar_lsu. Expected accesses are queued when an
// instruction is issued and checked when the request appears on the memory
// channel; expected lsu_out follows each completed access.
module tb_scalar_lsu;
    import common_pkg::*;

    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    warp_state_t    warp_state;
    logic           decoded_mem_read_enable;
    logic           decoded_mem_write_enable;
    logic [DW-1:0]  decoded_immediate;
    logic [DW-1:0]  rs1;
    logic [DW-1:0]  rs2;
    logic           mem_read_valid;
    logic [DW-1:0]  mem_read_address;
    logic           mem_read_ready;
    logic [DW-1:0]  mem_read_data;
    logic           mem_write_valid;
    logic [DW-1:0]  mem_write_address;
    logic [DW-1:0]  mem_write_data;
    logic           mem_write_ready;
    lsu_state_t     lsu_state;
    logic [DW-1:0]  lsu_out;
    logic           lsu_error;

    scalar_lsu #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .warp_state               (warp_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_immediate        (decoded_immediate),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            store;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] lsu;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model_lsu = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction for a single REQUEST cycle and queue its expectation.
    task automatic start_req(input bit ld, input bit st, input logic [DW-1:0] base,
                             input logic [DW-1:0] imm, input logic [DW-1:0] data,
                             input logic [DW-1:0] rdata);
        exp_t e;
        e.store = st;
        e.addr  = base + imm;
        e.wdata = data;
        if (!st) begin
            model_lsu = rdata;
        end
        e.lsu = model_lsu;
        sb.push_back(e);
        rs1 = base;
        decoded_immediate = imm;
        rs2 = data;
        decoded_mem_read_enable  = ld;
        decoded_mem_write_enable = st;
        warp_state = WARP_REQUEST;
        enable = 1'b1;
        tick();
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        warp_state = WARP_WAIT;
    endtask

    // Wait (bounded) for the request, pop its expectation and check it is held.
    task automatic observe_req(input string tag, input int hold, output exp_t e);
        int n = 0;
        while (!(mem_read_valid || mem_write_valid) && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid_seen"}, 64'(mem_read_valid | mem_write_valid), 64'd1);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            e.store = 1'b0; e.addr = '0; e.wdata = '0; e.lsu = '0;
        end else begin
            e = sb.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            if (i > 0) tick();
            check_eq({tag, "_state_req"}, 64'(lsu_state), 64'(LSU_REQUESTING));
            check_eq({tag, "_wvalid"}, 64'(mem_write_valid), 64'(e.store));
            check_eq({tag, "_rvalid"}, 64'(mem_read_valid), 64'(!e.store));
            if (e.store) begin
                check_eq({tag, "_waddr"}, 64'(mem_write_address), 64'(e.addr));
                check_eq({tag, "_wdata"}, 64'(mem_write_data), 64'(e.wdata));
            end else begin
                check_eq({tag, "_raddr"}, 64'(mem_read_address), 64'(e.addr));
            end
        end
    endtask

    // Complete the handshake and walk WAITING -> DONE -> IDLE.
    task automatic finish_txn(input string tag, input exp_t e, input logic [DW-1:0] rdata);
        if (e.store) begin
            mem_write_ready = 1'b1;
        end else begin
            mem_read_ready = 1'b1;
            mem_read_data  = rdata;
        end
        tick();
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = 32'h0BAD_F00D;
        check_eq({tag, "_state_wait"}, 64'(lsu_state), 64'(LSU_WAITING));
        check_eq({tag, "_valids_drop"}, 64'({mem_read_valid, mem_write_valid}), 64'd0);
        check_eq({tag, "_lsu_out"}, 64'(lsu_out), 64'(e.lsu));
        tick();
        check_eq({tag, "_state_done"}, 64'(lsu_state), 64'(LSU_DONE));
        warp_state = WARP_UPDATE;
        tick();
        warp_state = WARP_IDLE;
        check_eq({tag, "_state_idle"}, 64'(lsu_state), 64'(LSU_IDLE));
        tick();
        check_eq({tag, "_lsu_kept"}, 64'(lsu_out), 64'(e.lsu));
        check_eq({tag, "_error"}, 64'(lsu_error), 64'd0);
    endtask

    task automatic do_txn(input string tag, input bit ld, input bit st,
                          input logic [DW-1:0] base, input logic [DW-1:0] imm,
                          input logic [DW-1:0] data, input logic [DW-1:0] rdata,
                          input int hold);
        exp_t e;
        start_req(ld, st, base, imm, data, rdata);
        observe_req(tag, hold, e);
        finish_txn(tag, e, rdata);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b1;
        enable = 1'b0;
        warp_state = WARP_IDLE;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_immediate = '0;
        rs1 = '0;
        rs2 = '0;
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;

        // Reset state, with enable held high to show reset wins.
        tick();
        enable = 1'b1;
        tick();
        check_eq("rst_state", 64'(lsu_state), 64'(LSU_IDLE));
        check_eq("rst_valids", 64'({mem_read_valid, mem_write_valid}), 64'd0);
        check_eq("rst_addr", 64'({mem_read_address, mem_write_address}), 64'd0);
        check_eq("rst_wdata", 64'(mem_write_data), 64'd0);
        check_eq("rst_lsu_out", 64'(lsu_out), 64'd0);
        check_eq("rst_error", 64'(lsu_error), 64'd0);
        reset = 1'b0;

        // Idle must ignore ready and non-request phases.
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        warp_state = WARP_REQUEST;
        tick();
        check_eq("idle_no_dec", 64'(lsu_state), 64'(LSU_IDLE));
        warp_state = WARP_EXECUTE;
        decoded_mem_read_enable = 1'b1;
        tick();
        check_eq("idle_wrong_phase", 64'(lsu_state), 64'(LSU_IDLE));
        check_eq("idle_valids", 64'({mem_read_valid, mem_write_valid}), 64'd0);
        decoded_mem_read_enable = 1'b0;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        warp_state = WARP_IDLE;

        do_txn("load", 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 3);
        do_txn("store", 1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFC, 32'h0000_0055, 32'h0, 1);
        do_txn("wrap", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h1234_5678, 2);
        do_txn("both", 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0010, 32'hCAFE_0001, 32'h0, 2);

        // Reset in the middle of a request.
        start_req(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0008, 32'h0, 32'h5A5A_5A5A);
        observe_req("midrst", 1, e);
        reset = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h5A5A_5A5A;
        tick();
        reset = 1'b0;
        mem_read_ready = 1'b0;
        model_lsu = '0;
        check_eq("midrst_valid", 64'(mem_read_valid), 64'd0);
        check_eq("midrst_state", 64'(lsu_state), 64'(LSU_IDLE));
        check_eq("midrst_lsu_out", 64'(lsu_out), 64'd0);

        // Enable low freezes a pending request even with ready high.
        start_req(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0008, 32'h0, 32'h0000_AAAA);
        observe_req("freeze", 1, e);
        enable = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("freeze_valid", 64'(mem_read_valid), 64'd1);
            check_eq("freeze_addr", 64'(mem_read_address), 64'h48);
            check_eq("freeze_state", 64'(lsu_state), 64'(LSU_REQUESTING));
            check_eq("freeze_lsu_out", 64'(lsu_out), 64'd0);
        end
        mem_read_ready = 1'b0;
        enable = 1'b1;
        finish_txn("freeze", e, 32'h0000_AAAA);

`ifdef SCALAR_LSU_TIMEOUT_EN
        // No ready ever: request abandoned after TO cycles.
        start_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 32'hFFFF_FFFF);
        e = sb.pop_front();
        n = 0;
        while (mem_read_valid && n < 3 * TO) begin
            check_eq("to_addr", 64'(mem_read_address), 64'(e.addr));
            tick();
            n++;
        end
        check_eq("to_valid_cycles", 64'(n), 64'(TO));
        check_eq("to_state_done", 64'(lsu_state), 64'(LSU_DONE));
        check_eq("to_error", 64'(lsu_error), 64'd1);
        check_eq("to_lsu_out", 64'(lsu_out), 64'hFFFF_FFFF);
        warp_state = WARP_UPDATE;
        tick();
        warp_state = WARP_IDLE;
        check_eq("to_idle", 64'(lsu_state), 64'(LSU_IDLE));
        check_eq("to_error_held", 64'(lsu_error), 64'd1);
        start_req(1'b1, 1'b0, 32'h0000_0090, 32'h4, 32'h0, 32'h0000_0777);
        check_eq("to_error_clear", 64'(lsu_error), 64'd0);
        observe_req("to_next", 1, e);
        finish_txn("to_next", e, 32'h0000_0777);
`else
        // Without the timeout the request waits indefinitely.
        start_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 32'h0000_0777);
        observe_req("noto", 1, e);
        n = 0;
        while (mem_read_valid && n < 3 * TO) begin
            tick();
            n++;
        end
        check_eq("noto_valid_cycles", 64'(n), 64'(3 * TO));
        check_eq("noto_state", 64'(lsu_state), 64'(LSU_REQUESTING));
        check_eq("noto_error", 64'(lsu_error), 64'd0);
        finish_txn("noto", e, 32'h0000_0777);
`endif

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
